// File: rtl/divisor_ruta_datos.sv
// Restoring shift-subtract divider datapath driven by a one-hot control FSM state vector.
// Optional illegal-state checker enabled with `define DIV_ONEHOT_CHECK_EN.
module divisor_ruta_datos #(
  parameter int unsigned ANCHO  = 16,
  parameter int unsigned CONT_W = 5
) (
  input  logic              reloj,
  input  logic              reset,
  input  logic              go,
  input  logic [7:0]        Est,
  input  logic [ANCHO-1:0]  dividendo,
  input  logic [ANCHO-1:0]  divisor,
  output logic              divisorNoCero,
  output logic              Cont16NoCero,
  output logic [ANCHO-1:0]  cociente,
  output logic [ANCHO-1:0]  residuo,
  output logic              listo,
  output logic              error,
  output logic              fallo_estado
);

  localparam int unsigned SUB_W = ANCHO + 1;

  logic [ANCHO-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
  logic [ANCHO-1:0]  r_q, r_d, q_q, q_d, diff_q, diff_d;
  logic [ANCHO-1:0]  coc_q, coc_d, res_q, res_d;
  logic [CONT_W-1:0] cnt_q, cnt_d;
  logic              neg_q, neg_d, err_q, err_d;
  logic [SUB_W-1:0]  sub_c;
  logic              hold_c;

`ifdef DIV_ONEHOT_CHECK_EN
  logic first_q, fallo_q, bad_c;

  // Est==0 is tolerated only on the first cycle after reset release.
  assign bad_c = ($countones(Est) != 1) && !(first_q && (Est == 8'd0));

  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      first_q <= 1'b1;
      fallo_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      fallo_q <= fallo_q | bad_c;
    end
  end

  assign hold_c       = fallo_q | bad_c;
  assign fallo_estado = fallo_q;
  assign listo        = Est[7] & ~fallo_q;
`else
  assign hold_c       = 1'b0;
  assign fallo_estado = 1'b0;
  assign listo        = Est[7];
`endif

  assign divisorNoCero = (dvs_q != '0);
  assign Cont16NoCero  = (cnt_q != '0);
  assign cociente      = coc_q;
  assign residuo       = res_q;
  assign error         = err_q;

  // Extra top bit of the difference is the borrow: set when R < divisor.
  assign sub_c = {1'b0, r_q} - {1'b0, dvs_q};

  // Register action of the currently active FSM state.
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    r_d    = r_q;
    q_d    = q_q;
    diff_d = diff_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    coc_d  = coc_q;
    res_d  = res_q;
    err_d  = err_q;
    if (!hold_c) begin
      if (Est[0]) begin
        if (go) begin
          dvd_d = dividendo;
          dvs_d = divisor;
        end
      end else if (Est[1]) begin
        if (!divisorNoCero) begin
          coc_d = '1;
          res_d = dvd_q;
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
      end else if (Est[2]) begin
        r_d   = '0;
        q_d   = dvd_q;
        cnt_d = CONT_W'(ANCHO);
      end else if (Est[3]) begin
        r_d = {r_q[ANCHO-2:0], q_q[ANCHO-1]};
        q_d = {q_q[ANCHO-2:0], 1'b0};
      end else if (Est[4]) begin
        {neg_d, diff_d} = sub_c;
        cnt_d           = cnt_q - CONT_W'(1);
      end else if (Est[5]) begin
        if (!neg_q) begin
          r_d    = diff_q;
          q_d[0] = 1'b1;
        end
      end else if (Est[6]) begin
        coc_d = q_q;
        res_d = r_q;
      end
    end
  end

  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      diff_q <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      coc_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      r_q    <= r_d;
      q_q    <= q_d;
      diff_q <= diff_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
      coc_q  <= coc_d;
      res_q  <= res_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_divisor_ruta_datos.sv
// Directed bench for divisor_ruta_datos; the bench plays the role of the one-hot control FSM.
module tb_divisor_ruta_datos;

  logic        reloj, reset, go;
  logic [7:0]  Est;
  logic [15:0] dividendo, divisor;
  logic        divisorNoCero, Cont16NoCero, listo, error, fallo_estado;
  logic [15:0] cociente, residuo;

  int n_checks = 0;
  int n_pass   = 0;

  divisor_ruta_datos #(.ANCHO(16), .CONT_W(5)) dut (
    .reloj(reloj), .reset(reset), .go(go), .Est(Est),
    .dividendo(dividendo), .divisor(divisor),
    .divisorNoCero(divisorNoCero), .Cont16NoCero(Cont16NoCero),
    .cociente(cociente), .residuo(residuo), .listo(listo),
    .error(error), .fallo_estado(fallo_estado)
  );

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  function automatic logic [7:0] fsm_next(input logic [7:0] s, input logic g,
                                          input logic dnz, input logic cnz);
    case (s)
      8'h01:   return g ? 8'h02 : 8'h01;
      8'h02:   return dnz ? 8'h04 : 8'h80;
      8'h04:   return 8'h08;
      8'h08:   return 8'h10;
      8'h10:   return 8'h20;
      8'h20:   return cnz ? 8'h08 : 8'h40;
      8'h40:   return 8'h80;
      8'h80:   return g ? 8'h80 : 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // One clock of the modelled FSM: next state is decided from pre-edge feedback.
  task automatic tick();
    logic [7:0] nxt;
    nxt = fsm_next(Est, go, divisorNoCero, Cont16NoCero);
    @(posedge reloj);
    #1 Est = nxt;
    #1;
  endtask

  task automatic run_div(input string name, input logic [15:0] dvd, input logic [15:0] dvs,
                         input bit scramble, input logic [15:0] exp_q, input logic [15:0] exp_r,
                         input logic exp_err, input int exp_lat);
    int edges, est5_n, fall_idx;
    dividendo = dvd;
    divisor   = dvs;
    go        = 1'b1;
    edges = 0; est5_n = 0; fall_idx = 0;
    tick();
    edges = 1;
    go = 1'b0;
    n_checks++;
    if (divisorNoCero !== (dvs != 16'd0))
      $display("FAIL %s dnz_est1: got %b want %b", name, divisorNoCero, (dvs != 16'd0));
    else n_pass++;
    if (scramble) begin
      dividendo = 16'($urandom);
      divisor   = 16'($urandom);
    end
    while (!listo && edges < 100) begin
      tick();
      edges++;
      if (Est == 8'h20) begin
        est5_n++;
        if (!Cont16NoCero && fall_idx == 0) fall_idx = est5_n;
      end
    end
    n_checks++;
    if (edges !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, edges, exp_lat);
    else n_pass++;
    n_checks++;
    if (cociente !== exp_q) $display("FAIL %s cociente: got %h want %h", name, cociente, exp_q);
    else n_pass++;
    n_checks++;
    if (residuo !== exp_r) $display("FAIL %s residuo: got %h want %h", name, residuo, exp_r);
    else n_pass++;
    n_checks++;
    if (error !== exp_err) $display("FAIL %s error: got %b want %b", name, error, exp_err);
    else n_pass++;
    if (dvs != 16'd0) begin
      n_checks++;
      if (fall_idx !== 16) $display("FAIL %s cnz_fall: got Est5 #%0d want #16", name, fall_idx);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (listo !== 1'b0 || cociente !== exp_q || residuo !== exp_r || error !== exp_err)
      $display("FAIL %s persist: got listo=%b q=%h r=%h e=%b want listo=0 q=%h r=%h e=%b",
               name, listo, cociente, residuo, error, exp_q, exp_r, exp_err);
    else n_pass++;
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (cociente !== 16'd0 || residuo !== 16'd0 || error !== 1'b0 || listo !== 1'b0 ||
        divisorNoCero !== 1'b0 || Cont16NoCero !== 1'b0 || fallo_estado !== 1'b0)
      $display("FAIL %s: got q=%h r=%h e=%b listo=%b dnz=%b cnz=%b fallo=%b want all 0",
               name, cociente, residuo, error, listo, divisorNoCero, Cont16NoCero, fallo_estado);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0; Est = 8'h00; go = 1'b0; dividendo = 16'd0; divisor = 16'd0;
    repeat (3) @(posedge reloj);
    #1;
    check_all_zero("reset_state");
    @(negedge reloj);
    reset = 1'b1;
    Est   = 8'h01;
    #1;
  endtask

  task automatic test_basic();
    run_div("div_100_7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 52);
    run_div("div_1000_33", 16'd1000, 16'd33, 1'b0, 16'd30, 16'd10, 1'b0, 52);
  endtask

  task automatic test_max_operands();
    run_div("div_ffff_1", 16'hFFFF, 16'd1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 52);
    run_div("div_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 16'd1, 16'd0, 1'b0, 52);
  endtask

  task automatic test_div_zero();
    run_div("div_5_0", 16'd5, 16'd0, 1'b0, 16'hFFFF, 16'd5, 1'b1, 2);
    run_div("err_clear_40_6", 16'd40, 16'd6, 1'b0, 16'd6, 16'd4, 1'b0, 52);
  endtask

  task automatic test_late_change();
    run_div("late_3_10", 16'd3, 16'd10, 1'b1, 16'd0, 16'd3, 1'b0, 52);
  endtask

  task automatic test_reset_mid();
    int k;
    dividendo = 16'd100; divisor = 16'd7; go = 1'b1;
    tick();
    go = 1'b0;
    repeat (10) tick();
    k = 0;
    while (Est != 8'h10 && k < 10) begin tick(); k++; end
    n_checks++;
    if (Est !== 8'h10) $display("FAIL reset_mid_reach_est4: got %h want 10", Est);
    else n_pass++;
    reset = 1'b0;
    Est   = 8'h00;
    #1;
    check_all_zero("reset_mid_async");
    @(negedge reloj);
    reset = 1'b1;
    Est   = 8'h01;
    #1;
    run_div("after_reset_40_6", 16'd40, 16'd6, 1'b0, 16'd6, 16'd4, 1'b0, 52);
  endtask

  task automatic test_onehot();
`ifdef DIV_ONEHOT_CHECK_EN
    logic [15:0] cq, rq;
    logic        cnz;
    cq = cociente; rq = residuo;
    dividendo = 16'd100; divisor = 16'd7; go = 1'b1;
    tick();
    go = 1'b0;
    repeat (6) tick();
    cnz = Cont16NoCero;
    @(posedge reloj);
    #1 Est = 8'b0000_1100;
    @(posedge reloj);
    #1 Est = 8'h80;
    #1;
    n_checks++;
    if (fallo_estado !== 1'b1 || listo !== 1'b0)
      $display("FAIL onehot_flag: got fallo=%b listo=%b want fallo=1 listo=0", fallo_estado, listo);
    else n_pass++;
    Est = 8'h40;
    repeat (3) @(posedge reloj);
    #1 Est = 8'h80;
    #1;
    n_checks++;
    if (fallo_estado !== 1'b1 || listo !== 1'b0 || cociente !== cq || residuo !== rq ||
        Cont16NoCero !== cnz)
      $display("FAIL onehot_frozen: got fallo=%b listo=%b q=%h r=%h cnz=%b want 1 0 %h %h %b",
               fallo_estado, listo, cociente, residuo, Cont16NoCero, cq, rq, cnz);
    else n_pass++;
    reset = 1'b0;
    Est   = 8'h00;
    #1;
    check_all_zero("onehot_reset_clears");
    @(negedge reloj);
    reset = 1'b1;
    Est   = 8'h01;
    #1;
`else
    n_checks++;
    if (fallo_estado !== 1'b0) $display("FAIL fallo_tied: got %b want 0", fallo_estado);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_div_zero();
    test_late_change();
    test_reset_mid();
    test_onehot();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/divisor_ruta_datos.md
Name: divisor_ruta_datos

Overview:
- Restoring shift-subtract divider datapath, directly downstream of the 8-state one-hot divider control FSM.
- Consumes the FSM's one-hot state vector Est[7:0] and performs the register action of the active state.
- Feeds back the two FSM decision inputs: divisorNoCero and Cont16NoCero.
- Produces an ANCHO-bit quotient, an ANCHO-bit remainder, and done/error status.

Parameters:
- ANCHO, 16, operand/quotient/remainder width in bits.
- CONT_W, 5, iteration counter width; must hold the value ANCHO.

Ports:
- reloj  input  1  clock; all registers update on rising edge.
- reset  input  1  asynchronous, active-low reset.
- go  input  1  start request, same signal the FSM receives.
- Est  input  8  one-hot FSM state, Est[k] = state k.
- dividendo  input  ANCHO  dividend operand.
- divisor  input  ANCHO  divisor operand.
- divisorNoCero  output  1  1 when captured divisor register != 0 (combinational from register).
- Cont16NoCero  output  1  1 when iteration counter != 0 (combinational from register).
- cociente  output  ANCHO  registered quotient result.
- residuo  output  ANCHO  registered remainder result.
- listo  output  1  result valid; equals Est[7].
- error  output  1  registered; 1 = last operation was a division by zero.
- fallo_estado  output  1  sticky illegal-state flag; see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - Cleared: dividend reg, divisor reg, R (remainder acc), Q (quotient shift), diff, neg, count, cociente, residuo, error, fallo_estado.
  - Outputs during reset: divisorNoCero=0, Cont16NoCero=0.
- Per-state actions, on the edge where the state is active:
  - Est0 & go: capture dividendo, divisor into operand regs. Est0 & !go: hold everything.
  - Est1 & !divisorNoCero: cociente<={ANCHO{1}}, residuo<=dividend reg, error<=1.
  - Est1 & divisorNoCero: error<=0.
  - Est2: R<=0, Q<=dividend reg, count<=ANCHO.
  - Est3: {R,Q} <= {R,Q} << 1; R receives Q MSB; Q[0]<=0.
  - Est4: {neg,diff} <= {1'b0,R} - {1'b0,divisor reg}, computed ANCHO+1 bits wide; count<=count-1.
  - Est5: if !neg then R<=diff, Q[0]<=1; else R and Q hold.
  - Est6: cociente<=Q, residuo<=R.
  - Est7: hold all registers.
- Cont16NoCero in Est5 reflects the post-decrement count.
  - The FSM loops Est3->Est4->Est5 exactly ANCHO times, then goes to Est6.
- Latency, go sampled high in Est0 at edge 0:
  - Est1 at edge 1, Est2 at edge 2.
  - Loop edges 3..50.
  - Est6 at edge 51; results written at edge 52; listo=1 from edge 52.
  - Divide-by-zero path: results written at edge 2, listo=1 from edge 2.
- Operands are captured only in Est0&go. Input changes after that are ignored until the next capture.
- cociente, residuo and error persist after listo falls, until the next Est1/Est6 write.
- Est all-zero (FSM in reset): every register holds.
- Counter never underflows: it is decremented only in Est4 and reloaded in Est2.

Optional Feature:
- Macro: DIV_ONEHOT_CHECK_EN.
- With the macro:
  - Any cycle where Est is not exactly one-hot (popcount != 1) sets fallo_estado<=1.
  - Exception: Est==0 for the first cycle after reset release.
  - fallo_estado is sticky until reset.
  - While fallo_estado=1, all datapath registers hold and listo is forced to 0.
- Without the macro: fallo_estado is tied 0 and no checker logic is built.

Test Plan:
- dividendo=100, divisor=7, go pulse -> listo at edge 52 after go; cociente=14, residuo=2, error=0.
- dividendo=16'hFFFF, divisor=1 -> cociente=16'hFFFF, residuo=0; Cont16NoCero falls in the 16th Est5.
- dividendo=5, divisor=0 -> divisorNoCero=0 in Est1; cociente=16'hFFFF, residuo=5, error=1; listo at edge 2.
- dividendo=3, divisor=10, with both operand inputs changed to random values after edge 1 -> cociente=0, residuo=3 (late changes ignored).
- reset=0 asserted during the Est4 loop of 100/7, then a new go with 40/6 -> all outputs 0 immediately on reset; second result cociente=6, residuo=4.
- DIV_ONEHOT_CHECK_EN defined, force Est=8'b00001100 for one cycle mid-operation -> fallo_estado=1 and held; listo stays 0; registers frozen.
